// File: rtl/dual_speed_counter_pkg.sv
// Shared defaults and the prescaler width helper for the dual-rate activity counter.
package dual_speed_counter_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_SLOW_DIV = 100_000_000;
  localparam int DEFAULT_FAST_DIV = 25_000_000;

  // A divisor of 1 or 2 still needs one prescaler bit.
  function automatic int presc_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/dual_rate_tick_gen.sv
// Synchronizes the rate select and produces a one-cycle tick every SLOW_DIV or FAST_DIV clocks.
module dual_rate_tick_gen
  import dual_speed_counter_pkg::*;
#(
  parameter int SLOW_DIV = DEFAULT_SLOW_DIV,
  parameter int FAST_DIV = DEFAULT_FAST_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sel,
  output logic tick
);

  localparam int PW = presc_width(SLOW_DIV);
  localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_DIV - 1);
  localparam logic [PW-1:0] FAST_LAST = PW'(FAST_DIV - 1);

  logic          sel_meta_reg;
  logic          sel_s_reg;
  logic          sel_p_reg;
  logic [PW-1:0] presc_reg;
  logic [PW-1:0] presc_next;
  logic [PW-1:0] last;
  logic          change;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_meta_reg <= 1'b0;
      sel_s_reg    <= 1'b0;
      sel_p_reg    <= 1'b0;
    end else begin
      sel_meta_reg <= sel;
      sel_s_reg    <= sel_meta_reg;
      sel_p_reg    <= sel_s_reg;
    end
  end

  assign change = sel_s_reg ^ sel_p_reg;
  assign last   = sel_s_reg ? FAST_LAST : SLOW_LAST;

  // A rate change always restarts the period, so a prescaler left above the
  // new terminal value by the old rate can never run past the compare.
  always_comb begin
    presc_next = presc_reg + PW'(1);
    tick       = 1'b0;
    if (change) begin
      presc_next = '0;
    end else if (presc_reg == last) begin
      presc_next = '0;
      tick       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_reg <= '0;
    else        presc_reg <= presc_next;
  end

endmodule

// File: rtl/dual_speed_counter.sv
// Free-running counter that advances on each tick from the dual-rate tick generator.
module dual_speed_counter
  import dual_speed_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SLOW_DIV = DEFAULT_SLOW_DIV,
  parameter int FAST_DIV = DEFAULT_FAST_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  output logic [WIDTH-1:0] count
);

  logic             tick;
  logic [WIDTH-1:0] count_reg;

  dual_rate_tick_gen #(
    .SLOW_DIV(SLOW_DIV),
    .FAST_DIV(FAST_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .sel  (sel),
    .tick (tick)
  );

  // Wraps silently from all-ones to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count_reg <= '0;
    else if (tick) count_reg <= count_reg + WIDTH'(1);
  end

  assign count = count_reg;

endmodule

// File: tb/tb_dual_speed_counter.sv
// Self-checking bench for dual_speed_counter with SLOW_DIV=8, FAST_DIV=2.
module tb_dual_speed_counter;

  localparam int SLOW = 8;
  localparam int FAST = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] count;

  int checks = 0;
  int failures = 0;

  // Reference: edges elapsed since the last period restart; sel history as sampled at edges.
  logic [7:0] m_count;
  int         m_phase;
  logic       smp [3];
  int         edge_n;

  dual_speed_counter #(.WIDTH(8), .SLOW_DIV(SLOW), .FAST_DIV(FAST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sel  (sel),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v_sel;
    int         edges;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 8'd0;
    m_phase = 0;
    for (int i = 0; i < 3; i++) smp[i] = 1'b0;
    edge_n = 0;
  endtask

  task automatic model_edge();
    logic s_now;
    logic s_old;
    int   div;
    s_now = smp[1];
    s_old = smp[2];
    div = s_now ? FAST : SLOW;
    if (s_now != s_old) begin
      m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == div) begin
        m_phase = 0;
        m_count = m_count + 8'd1;
      end
    end
    smp[2] = smp[1];
    smp[1] = smp[0];
    smp[0] = sel;
    edge_n++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model", int'(count), int'(m_count));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_sel(input logic v);
    @(negedge clk);
    sel = v;
  endtask

  task automatic do_reset(input logic v);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sel = v;
    model_reset();
    #1;
    check("reset_async", int'(count), 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", int'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 7,  8'd0};
    vecs[1] = '{1'b0, 8,  8'd1};
    vecs[2] = '{1'b0, 80, 8'd10};
    vecs[3] = '{1'b1, 4,  8'd0};
    vecs[4] = '{1'b1, 5,  8'd1};
    vecs[5] = '{1'b1, 23, 8'd10};
    vecs[6] = '{1'b0, 1,  8'd0};
    vecs[7] = '{1'b1, 7,  8'd2};

    for (int v = 0; v < 8; v++) begin
      do_reset(vecs[v].v_sel);
      steps(vecs[v].edges);
      check($sformatf("vec%0d", v), int'(count), int'(vecs[v].exp_count));
      $display("vec %0d sel=%0b edges=%0d count=%0d", v, vecs[v].v_sel, vecs[v].edges, count);
    end

    // Slow to fast while the prescaler sits at 5, then back to slow.
    do_reset(1'b0);
    steps(5);
    set_sel(1'b1);
    steps(3);
    check("sw_restart_no_tick", int'(count), 0);
    steps(2);
    check("sw_fast_first", int'(count), 1);
    steps(2);
    check("sw_fast_second", int'(count), 2);
    set_sel(1'b0);
    steps(3);
    check("sw_back_restart", int'(count), 3);
    steps(7);
    check("sw_back_no_extra", int'(count), 3);
    step();
    check("sw_back_slow_tick", int'(count), 4);
    $display("switch sequence count=%0d", count);

    // Wrap at 255 -> 0 in fast mode.
    do_reset(1'b1);
    steps(513);
    check("wrap_255", int'(count), 255);
    step();
    check("wrap_hold", int'(count), 255);
    step();
    check("wrap_zero", int'(count), 0);
    $display("wrap sequence count=%0d", count);

    // Asynchronous reset mid-count at 37.
    do_reset(1'b1);
    steps(77);
    check("pre_async_37", int'(count), 37);
    @(negedge clk);
    sel = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", int'(count), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    steps(7);
    check("async_resume_7", int'(count), 0);
    step();
    check("async_resume_8", int'(count), 1);
    $display("async reset sequence count=%0d", count);

    // Random select activity, including sub-cycle glitches that no edge samples.
    do_reset(1'($urandom_range(0, 1)));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        set_sel(~sel);
      end else if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        #1 sel = ~sel;
        #2 sel = ~sel;
      end
      step();
    end
    $display("random run done count=%0d model=%0d", count, m_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout edge=%0d actual=running required=finished", edge_n);
    $fatal(1, "timeout");
  end

endmodule
